// File: rtl/cfa_window_3x3.sv
// Bayer 3x3 neighbourhood generator: two line buffers plus a 3x3 shift window,
// emitting one window (with its RGGB phase) per interior pixel of a raster stream.
module cfa_window_3x3 #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_W-1:0]     pix_in,
    output logic                  win_valid,
    output logic [9*DATA_W-1:0]   win,
    output logic [1:0]            phase,
    output logic                  frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [DATA_W-1:0] lb0_q [IMG_W];
    logic [DATA_W-1:0] lb1_q [IMG_W];
    logic [DATA_W-1:0] top, mid;
    // Window storage indexed [column][row]; column 2 is the newest.
    logic [DATA_W-1:0] wcol_q [3][3];
    logic [DATA_W-1:0] wcol_d [3][3];
    logic              win_valid_q, win_valid_d;
    logic [1:0]        phase_q, phase_d;
    logic              frame_done_q, frame_done_d;

    assign top = lb1_q[col_q];
    assign mid = lb0_q[col_q];

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        col_d        = col_q;
        row_d        = row_q;
        wcol_d       = wcol_q;
        phase_d      = phase_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        if (en) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            wcol_d[0]    = wcol_q[1];
            wcol_d[1]    = wcol_q[2];
            wcol_d[2][0] = top;
            wcol_d[2][1] = mid;
            wcol_d[2][2] = pix_in;
            win_valid_d  = (row_q >= RW'(2)) && (col_q >= CW'(2));
            frame_done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
            // Centre sits one line up and one column left of the incoming pixel.
            if (win_valid_d) begin
                phase_d = {~row_q[0], ~col_q[0]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            phase_q      <= '0;
            frame_done_q <= 1'b0;
            for (int c = 0; c < 3; c++) begin
                for (int r = 0; r < 3; r++) begin
                    wcol_q[c][r] <= '0;
                end
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            col_q        <= col_d;
            row_q        <= row_d;
            wcol_q       <= wcol_d;
            win_valid_q  <= win_valid_d;
            phase_q      <= phase_d;
            frame_done_q <= frame_done_d;
        end
    end

    // NOTE: line buffers carry no reset; stale lines are always overwritten before use.
    always_ff @(posedge clk) begin
        if (en) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= pix_in;
        end
    end

    always_comb begin
        win = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win[(3*r+c)*DATA_W +: DATA_W] = wcol_q[c][r];
            end
        end
    end

    assign win_valid  = win_valid_q;
    assign phase      = phase_q;
    assign frame_done = frame_done_q;

endmodule
